// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM sharing one memory port; outputs are a Moore decode of state, with fetch/branch/store strobes gated by mem_ready/Flags.
// Latency: 3-5 cycles per instruction plus one per mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE; stalls by holding state until mem_ready.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [3:0]       Flags,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             pc_write, mem_write, ir_write, reg_write;
    logic             br_taken;
    logic             flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = flag_z;
            3'b001:  br_taken = !flag_z;
            3'b100:  br_taken = flag_n ^ flag_v;
            3'b101:  br_taken = !(flag_n ^ flag_v);
            3'b110:  br_taken = !flag_c;
            3'b111:  br_taken = flag_c;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (opcode)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BR:                  ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                pc_write = br_taken;
                state_d  = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR2;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: begin
                // TRAP, and the unused encoding 14 falls into it as well
                illegal = 1'b1;
                state_d = S_TRAP;
            end
        endcase
    end

    // An instruction retires on the edge that returns to FETCH; TRAP never returns.
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign PCWrite   = reset & pc_write;
    assign IRWrite   = reset & ir_write;
    assign RegWrite  = reset & reg_write;
    assign MemWrite  = reset & mem_write;
    assign state_out = state_q;
    assign instret   = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level step-plan model plus operand-level branch relations.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [3:0]  Flags = 4'd0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0]  ImmSrc;
    logic [3:0]  state_out;
    logic [31:0] instret;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .Flags(Flags),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal),
        .state_out(state_out), .instret(instret)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          plan[$];
    logic [31:0] exp_cnt = 32'd0;
    bit          rand_mode = 1'b0;
    logic [6:0]  nxt_opc = OP_R;
    logic [2:0]  nxt_f3 = 3'd0;
    bit          mr_q[$];
    bit          force_flags = 1'b0;
    bit          force_taken = 1'b0;
    bit          rel_eq, rel_lt, rel_ltu;
    logic [3:0]  trace[$];
    int          mw_cnt = 0;
    logic        br_pcw = 1'b0;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == OP_LOAD || o == OP_I || o == OP_JALR) return 3'b000;
        if (o == OP_STORE) return 3'b001;
        if (o == OP_BR) return 3'b010;
        if (o == OP_JAL) return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    // Steps an instruction walks through after its fetch completes.
    task automatic load_plan(input logic [6:0] o);
        case (o)
            OP_LOAD:  plan = '{1, 2, 3, 4};
            OP_STORE: plan = '{1, 2, 5};
            OP_R:     plan = '{1, 6, 8};
            OP_I:     plan = '{1, 7, 8};
            OP_JAL:   plan = '{1, 9, 8};
            OP_BR:    plan = '{1, 10};
            OP_JALR:  plan = '{1, 11, 12, 8};
            OP_LUI:   plan = '{1, 13, 8};
            OP_AUIPC: plan = '{1, 8};
            default:  plan = '{1, 15};
        endcase
    endtask

    function automatic bit branch_taken(input logic [2:0] f3);
        if (force_flags) return force_taken;
        case (f3)
            3'b000:  return rel_eq;
            3'b001:  return !rel_eq;
            3'b100:  return rel_lt;
            3'b101:  return !rel_lt;
            3'b110:  return rel_ltu;
            3'b111:  return !rel_ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [20:0] expect_vec(input int st);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, op;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; op = 0;
        case (st)
            0:  begin sb = 2; rs = 2; irw = mem_ready; pcw = mem_ready; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; op = 2; end
            7:  begin sa = 2; sb = 1; op = 2; end
            8:  rw = 1;
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; op = 1; pcw = branch_taken(funct3); end
            11: begin sa = 2; sb = 1; end
            12: begin sa = 1; sb = 2; pcw = 1; end
            13: begin sa = 3; sb = 1; end
            default: ill = 1;
        endcase
        if (!reset) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        return {pcw, adr, mw, irw, rs, sa, sb, op, imm_of(opcode), rw, ill, 4'(st)};
    endfunction

    task automatic new_operands();
        logic [31:0] a, b, d;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 4) == 0) b = a ^ 32'h8000_0000;
        d = a - b;
        Flags   = {d[31], d == 32'd0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
        rel_eq  = (a == b);
        rel_lt  = ($signed(a) < $signed(b));
        rel_ltu = (a < b);
    endtask

    task automatic pick_random();
        case ($urandom_range(0, 10))
            0: nxt_opc = OP_LOAD;   1: nxt_opc = OP_STORE;  2: nxt_opc = OP_R;
            3: nxt_opc = OP_I;      4: nxt_opc = OP_JAL;    5: nxt_opc = OP_BR;
            6: nxt_opc = OP_JALR;   7: nxt_opc = OP_LUI;    8: nxt_opc = OP_AUIPC;
            9: nxt_opc = OP_BR;
            default: nxt_opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OP_R;
        endcase
        nxt_f3 = 3'($urandom);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        logic [20:0] got, exp;
        int cur;
        if (mr_q.size() > 0) mem_ready = mr_q.pop_front();
        else mem_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rand_mode) reset = ($urandom_range(0, 99) != 0);
        if (!force_flags) new_operands();
        @(negedge clk);
        cur = plan[0];
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               ImmSrc, RegWrite, illegal, state_out};
        exp = expect_vec(cur);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, exp);
        end
        chk("instret", instret, exp_cnt);
        trace.push_back(state_out);
        if (MemWrite) mw_cnt++;
        if (state_out == 4'd10) br_pcw = PCWrite;
        @(posedge clk);
        #1;
        if (!reset) begin
            plan = '{0};
            exp_cnt = 32'd0;
        end else if (cur == 15) begin
        end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
        end else if (cur == 0) begin
            if (rand_mode) pick_random();
            opcode = nxt_opc;
            funct3 = nxt_f3;
            load_plan(nxt_opc);
        end else begin
            void'(plan.pop_front());
            if (plan.size() == 0) begin
                plan.push_back(0);
                exp_cnt = exp_cnt + 32'd1;
            end
        end
    endtask

    function automatic logic [31:0] packed_trace();
        logic [31:0] p;
        p = 32'd0;
        foreach (trace[i]) p = {p[27:0], trace[i]};
        return p;
    endfunction

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [31:0] base;
        plan = '{0};
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(2);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_instret", instret, 32'd0);

        reset = 1'b1;
        nxt_opc = OP_R; nxt_f3 = 3'd0;
        trace.delete();
        run(4);
        chk("add_states", packed_trace(), 32'h0000_0168);
        chk("add_instret", instret, 32'd1);
        chk("add_back_fetch", 32'(state_out), 32'd0);

        nxt_opc = OP_LOAD; nxt_f3 = 3'd2;
        mr_q = '{1, 1, 1, 0, 0, 1, 1};
        trace.delete();
        run(7);
        chk("lw_states", packed_trace(), 32'h0012_3334);
        chk("lw_back_fetch", 32'(state_out), 32'd0);

        force_flags = 1'b1;
        Flags = 4'b0100; force_taken = 1'b1;
        nxt_opc = OP_BR; nxt_f3 = 3'b000;
        br_pcw = 1'b0;
        run(3);
        chk("beq_taken", 32'(br_pcw), 32'd1);
        chk("beq_fetch1", 32'(state_out), 32'd0);
        Flags = 4'b0000; force_taken = 1'b0;
        br_pcw = 1'b1;
        run(3);
        chk("beq_not_taken", 32'(br_pcw), 32'd0);
        chk("beq_fetch2", 32'(state_out), 32'd0);
        force_flags = 1'b0;

        nxt_opc = OP_STORE; nxt_f3 = 3'd2;
        mr_q = '{1, 1, 1, 0, 0, 0, 1};
        mw_cnt = 0;
        base = instret;
        run(7);
        chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
        chk("sw_one_retire", instret - base, 32'd1);

        nxt_opc = 7'b1111111;
        base = instret;
        mr_q = '{1, 0, 1, 0, 1, 0, 1, 0};
        run(8);
        chk("trap_state", 32'(state_out), 32'd15);
        chk("trap_illegal", 32'(illegal), 32'd1);
        chk("trap_no_retire", instret, base);
        reset = 1'b0;
        run(1);
        chk("trap_reset_state", 32'(state_out), 32'd0);
        chk("trap_reset_illegal", 32'(illegal), 32'd0);

        reset = 1'b1;
        rand_mode = 1'b1;
        run(4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multi-cycle RV32I datapath over a single shared instruction/data memory port.
- Replaces the single-cycle combinational controller. The datapath holds the IR, OldPC, ALUOut and Data registers.
- Each instruction is broken into FETCH/DECODE/EXECUTE/MEM/WB steps. Memory accesses wait on a ready handshake.
- Also exposes a trap for illegal instructions and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0] from datapath
- funct3  in  3  IR[14:12]
- Flags  in  4  {N,Z,C,V} from ALU, combinational, current cycle; C=1 means no borrow (A>=B unsigned)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC <= Result
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR <= memory read data, OldPC <= PC
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero
- ALUSrcB  out  2  00=RD2, 01=Imm, 10=const 4
- ALUOp  out  2  00=add, 01=subtract (compare), 10=decode from funct3/funct7
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- RegWrite  out  1  register file write strobe
- illegal  out  1  high while in the TRAP state
- state_out  out  4  current state encoding, for debug
- instret  out  CNT_W  count of completed instructions

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, JALR=11, JALR2=12, LUI=13, TRAP=15.
- Reset (reset=0 at a clk edge): state<=FETCH, instret<=0.
- While reset=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Outputs are a Moore decode of state, except IRWrite, PCWrite and MemWrite, which are gated as listed below. Unlisted outputs are 0.
- ImmSrc is decoded combinationally from opcode in every state:
  - 0000011/0010011/1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111/0010111 -> U
  - other -> 000
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; otherwise go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut gets the target.
  - Next state by opcode: load/store -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BRANCH; 1100111 -> JALR; 0110111 -> LUI; 0010111 (AUIPC) -> ALUWB; other -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite is held high every cycle until mem_ready=1, then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (writes OldPC+4).
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite is set by funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C; 010/011 -> 0 (not taken, no trap).
  - Next state is FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, then JALR2.
- JALR2: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, then ALUWB.
- TRAP: illegal=1, all strobes 0. Sticky until reset.
- Cycle counts with mem_ready always 1: R/I/LUI/JAL 4, load 5, store 4, branch 3, AUIPC 3, JALR 5.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- instret increments by 1 on every clk edge where the next state is FETCH and the current state is not FETCH. It wraps modulo 2^CNT_W and never increments in TRAP.
- Reset mid-operation aborts the instruction immediately; no partial strobe occurs on or after the reset edge.

Test Plan:
- Reset held 2 cycles, mem_ready=1 -> state_out=0, instret=0, all strobes 0 during reset.
- add (opcode 0110011), mem_ready=1:
  - states 0,1,6,8, then back to 0
  - IRWrite=1 only in cycle 0, RegWrite=1 only in cycle 3, ALUOp=10 in EXECR
  - instret 0->1
- lw with mem_ready low for 2 cycles in MEMREAD:
  - states 0,1,2,3,3,3,4,0 (8 cycles)
  - AdrSrc=1 in MEMREAD, RegWrite=1 with ResultSrc=01 in MEMWB
- beq (funct3=000), Flags=0100 -> PCWrite=1 in BRANCH; repeat with Flags=0000 -> PCWrite=0. Both return to FETCH after 3 cycles.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, exactly one instret increment.
- opcode 1111111 -> DECODE then TRAP: illegal=1 and stays there with mem_ready toggling. Reset low -> FETCH, illegal=0.
